sw_seq_feeder: RTL and testbench

Parametrised sequence feeder for the Smith-Waterman core. It holds the query (t) and database (s) sequences in runtime-writable on-chip memories and streams them into `Top`. It replaces the fixed 64-PE, file-initialised feeder with programmable lengths, a host write port, pass counting and error flags. It sits between the host/FPGA shell and `Top`: t is burst-loaded on `i_set_t`, and s is returned in PE-array-wide chunks on each core request.

---
 rtl/sw_pkg.sv | 23 ++
 rtl/sw_sdp_ram.sv | 26 ++
 rtl/sw_seq_feeder.sv | 193 +++++++++++++++++++
 tb/tb_sw_seq_feeder.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sw_pkg.sv
// Shared constants and FSM state types for the Smith-Waterman feeder.
// Holds the PE array geometry, score widths and the feeder state enums.
package sw_pkg;

  localparam int PE_NUM         = 64;
  localparam int SYM_W          = 2;
  localparam int S_W            = PE_NUM * SYM_W;
  localparam int CNT_W          = $clog2(PE_NUM) + 1;
  localparam int MATCH_BIT      = 2;
  localparam int ALPHA_BETA_BIT = 16;

  typedef enum logic {
    T_IDLE,
    T_STREAM
  } t_state_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_READY,
    S_ISSUE
  } s_state_e;

endpackage

// File: rtl/sw_sdp_ram.sv
// Simple dual-port RAM: one write port, one synchronous read port.
// Ports: clk, i_we/i_waddr/i_wdata (write), i_raddr -> o_rdata (1-cycle read).
module sw_sdp_ram #(
  parameter int W     = 8,
  parameter int DEPTH = 16
) (
  input  logic                     clk,
  input  logic                     i_we,
  input  logic [$clog2(DEPTH)-1:0] i_waddr,
  input  logic [W-1:0]             i_wdata,
  input  logic [$clog2(DEPTH)-1:0] i_raddr,
  output logic [W-1:0]             o_rdata
);
  import sw_pkg::*;

  logic [W-1:0] r_mem [DEPTH];
  logic [W-1:0] r_rdata;

  always_ff @(posedge clk) begin
    if (i_we) r_mem[i_waddr] <= i_wdata;
    r_rdata <= r_mem[i_raddr];
  end

  assign o_rdata = r_rdata;

endmodule

// File: rtl/sw_seq_feeder.sv
// Streams query (t) bursts and database (s) chunks into the SW core.
// Ports: host write port, t burst control, core handshake, t/s outputs, error pulses.
module sw_seq_feeder #(
  parameter int PE_NUM  = 64,
  parameter int SYM_W   = 2,
  parameter int T_W     = 18,
  parameter int T_DEPTH = 1024,
  parameter int S_DEPTH = 256,
  parameter int LEN_W   = 15
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       i_wr_en,
  input  logic                       i_wr_sel,
  input  logic [$clog2(T_DEPTH)-1:0] i_wr_addr,
  input  logic [PE_NUM*SYM_W-1:0]    i_wr_data,
  input  logic [$clog2(T_DEPTH):0]   i_t_len,
  input  logic [LEN_W-1:0]           i_s_len,
  input  logic                       i_set_t,
  input  logic                       i_core_busy,
  input  logic                       i_request_s,
  output logic [T_W-1:0]             o_t,
  output logic                       o_t_valid,
  output logic [PE_NUM*SYM_W-1:0]    o_s,
  output logic [$clog2(PE_NUM):0]    o_s_cnt,
  output logic [15:0]                o_pass_cnt,
  output logic                       o_wr_err,
  output logic                       o_cfg_err
);
  import sw_pkg::*;

  localparam int SWD  = PE_NUM * SYM_W;
  localparam int CW   = $clog2(PE_NUM) + 1;
  localparam int TA_W = $clog2(T_DEPTH);
  localparam int SA_W = $clog2(S_DEPTH);
  localparam int TAW1 = TA_W + 1;
  localparam int LW1  = LEN_W + 1;
  localparam logic [TA_W:0]    T_LIM   = TAW1'(T_DEPTH);
  localparam logic [TA_W:0]    S_LIM   = TAW1'(S_DEPTH);
  localparam logic [LEN_W:0]   MAX_LEN = LW1'(S_DEPTH * PE_NUM);
  localparam logic [LEN_W-1:0] PE_L    = LEN_W'(PE_NUM);
  localparam logic [CW-1:0]    PE_C    = CW'(PE_NUM);

  t_state_e         r_t_state, w_t_next;
  s_state_e         r_s_state, w_s_next;
  logic             w_wr_range, w_wr_ok;
  logic             r_wr_err, r_cfg_err, w_cfg_err;
  logic [TA_W:0]    r_t_cnt, r_t_len, r_pend_len, w_start_len;
  logic             r_pend, w_t_start, w_t_last, r_t_vld;
  logic [T_W-1:0]   w_t_rd;
  logic [SA_W-1:0]  r_s_addr;
  logic [LEN_W-1:0] r_s_rem;
  logic [15:0]      r_pass;
  logic [CW-1:0]    r_s_cnt;
  logic             r_s_vld, w_issue, w_more, w_len_ok;
  logic [SWD-1:0]   w_s_rd, w_s_mask;

  assign w_wr_range = i_wr_sel ? ({1'b0, i_wr_addr} < S_LIM)
                               : ({1'b0, i_wr_addr} < T_LIM);
  assign w_wr_ok = i_wr_en && !i_core_busy
                && (r_t_state == T_IDLE) && w_wr_range;

  sw_sdp_ram #(.W(T_W), .DEPTH(T_DEPTH)) u_t_ram (
    .clk     (clk),
    .i_we    (w_wr_ok && !i_wr_sel),
    .i_waddr (i_wr_addr),
    .i_wdata (i_wr_data[T_W-1:0]),
    .i_raddr (r_t_cnt[TA_W-1:0]),
    .o_rdata (w_t_rd)
  );

  sw_sdp_ram #(.W(SWD), .DEPTH(S_DEPTH)) u_s_ram (
    .clk     (clk),
    .i_we    (w_wr_ok && i_wr_sel),
    .i_waddr (i_wr_addr[SA_W-1:0]),
    .i_wdata (i_wr_data),
    .i_raddr (r_s_addr),
    .o_rdata (w_s_rd)
  );

  // A set_t that collides with a write is replayed one cycle later.
  assign w_start_len = r_pend ? r_pend_len : i_t_len;
  assign w_t_start = (r_pend || (i_set_t && !i_wr_en))
                  && (w_start_len != '0);
  assign w_t_last = (r_t_cnt + 1'b1) == r_t_len;

  always_comb begin
    w_t_next = r_t_state;
    unique case (r_t_state)
      T_IDLE:   if (w_t_start) w_t_next = T_STREAM;
      T_STREAM: if (w_t_last) w_t_next = T_IDLE;
      default:  w_t_next = T_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_t_state  <= T_IDLE;
      r_t_cnt    <= '0;
      r_t_len    <= '0;
      r_pend     <= 1'b0;
      r_pend_len <= '0;
      r_t_vld    <= 1'b0;
      r_wr_err   <= 1'b0;
    end else begin
      r_t_state <= w_t_next;
      r_t_vld   <= (r_t_state == T_STREAM);
      r_wr_err  <= i_wr_en && !w_wr_ok;
      if (r_t_state == T_IDLE) begin
        r_t_cnt <= '0;
        r_pend  <= !r_pend && i_set_t && i_wr_en;
        if (!r_pend) r_pend_len <= i_t_len;
        if (w_t_start) r_t_len <= w_start_len;
      end else begin
        r_t_cnt <= r_t_cnt + 1'b1;
        r_pend  <= 1'b0;
      end
    end
  end

  assign w_len_ok = (i_s_len != '0) && ({1'b0, i_s_len} <= MAX_LEN);
  assign w_issue  = (r_s_state == S_ISSUE) && i_core_busy;
  assign w_more   = r_s_rem > PE_L;

  // r_s_vld blocks acceptance while a chunk is on the bus: 3-cycle cadence.
  always_comb begin
    w_s_next  = r_s_state;
    w_cfg_err = 1'b0;
    if (!i_core_busy) begin
      w_s_next = S_IDLE;
    end else begin
      unique case (r_s_state)
        S_IDLE:  w_s_next = S_READY;
        S_READY: if (i_request_s && !r_s_vld) begin
          if (w_len_ok) w_s_next = S_ISSUE;
          else w_cfg_err = 1'b1;
        end
        S_ISSUE: w_s_next = S_READY;
        default: w_s_next = S_IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_state <= S_IDLE;
      r_cfg_err <= 1'b0;
      r_s_vld   <= 1'b0;
      r_s_cnt   <= '0;
      r_s_addr  <= '0;
      r_s_rem   <= '0;
      r_pass    <= '0;
    end else begin
      r_s_state <= w_s_next;
      r_cfg_err <= w_cfg_err;
      r_s_vld   <= w_issue;
      r_s_cnt   <= '0;
      if (!i_core_busy || r_s_state == S_IDLE) begin
        r_s_addr <= '0;
        r_s_rem  <= i_s_len;
        r_pass   <= '0;
      end else if (w_issue) begin
        if (w_more) begin
          r_s_cnt  <= PE_C;
          r_s_addr <= r_s_addr + 1'b1;
          r_s_rem  <= r_s_rem - PE_L;
        end else begin
          r_s_cnt  <= r_s_rem[CW-1:0];
          r_s_addr <= '0;
          r_s_rem  <= i_s_len;
          if (r_pass != 16'hFFFF) r_pass <= r_pass + 1'b1;
        end
      end
    end
  end

  // r_s_cnt is 0 when idle, so the mask also blanks o_s.
  always_comb begin
    w_s_mask = '0;
    for (int i = 0; i < PE_NUM; i++) begin
      if (CW'(i) < r_s_cnt) w_s_mask[i*SYM_W +: SYM_W] = '1;
    end
  end

  assign o_t        = r_t_vld ? w_t_rd : '0;
  assign o_t_valid  = r_t_vld;
  assign o_s        = w_s_rd & w_s_mask;
  assign o_s_cnt    = r_s_cnt;
  assign o_pass_cnt = r_pass;
  assign o_wr_err   = r_wr_err;
  assign o_cfg_err  = r_cfg_err;

endmodule

// File: tb/tb_sw_seq_feeder.sv
// Directed bench for sw_seq_feeder: t bursts, s chunking, errors, reset.
// Uses default parameters (PE_NUM=64, SYM_W=2, T_W=18).
module tb_sw_seq_feeder;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         i_wr_en, i_wr_sel, i_set_t, i_core_busy, i_request_s;
  logic [9:0]   i_wr_addr;
  logic [127:0] i_wr_data;
  logic [10:0]  i_t_len;
  logic [14:0]  i_s_len;
  logic [17:0]  o_t;
  logic         o_t_valid;
  logic [127:0] o_s;
  logic [6:0]   o_s_cnt;
  logic [15:0]  o_pass_cnt;
  logic         o_wr_err, o_cfg_err;

  int n_chk = 0;
  int n_fail = 0;

  typedef struct {
    logic [14:0] len;
    logic        newss;
    int          cnt;
    int          addr;
    int          pass;
    logic        cfg;
  } vec_t;

  vec_t tbl[17];

  always #5 clk = ~clk;

  sw_seq_feeder dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .i_wr_en     (i_wr_en),
    .i_wr_sel    (i_wr_sel),
    .i_wr_addr   (i_wr_addr),
    .i_wr_data   (i_wr_data),
    .i_t_len     (i_t_len),
    .i_s_len     (i_s_len),
    .i_set_t     (i_set_t),
    .i_core_busy (i_core_busy),
    .i_request_s (i_request_s),
    .o_t         (o_t),
    .o_t_valid   (o_t_valid),
    .o_s         (o_s),
    .o_s_cnt     (o_s_cnt),
    .o_pass_cnt  (o_pass_cnt),
    .o_wr_err    (o_wr_err),
    .o_cfg_err   (o_cfg_err)
  );

  function automatic logic [127:0] s_word(input int k);
    return {4{32'h9E37_79B9 ^ (32'(k) * 32'h0101_0101)}};
  endfunction

  function automatic logic [127:0] s_exp(input int k, input int cnt);
    logic [127:0] w;
    w = s_word(k);
    for (int b = 0; b < 128; b++) begin
      if (b >= cnt * 2) w[b] = 1'b0;
    end
    return w;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string nm, input logic [127:0] act,
                     input logic [127:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask

  task automatic wr(input logic sel, input int addr,
                    input logic [127:0] data);
    i_wr_en   = 1'b1;
    i_wr_sel  = sel;
    i_wr_addr = 10'(addr);
    i_wr_data = data;
    step();
    i_wr_en   = 1'b0;
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, " o_t"}, 128'(o_t), 128'(0));
    chk({nm, " o_t_valid"}, 128'(o_t_valid), 128'(0));
    chk({nm, " o_s"}, o_s, 128'(0));
    chk({nm, " o_s_cnt"}, 128'(o_s_cnt), 128'(0));
    chk({nm, " o_pass_cnt"}, 128'(o_pass_cnt), 128'(0));
    chk({nm, " o_wr_err"}, 128'(o_wr_err), 128'(0));
    chk({nm, " o_cfg_err"}, 128'(o_cfg_err), 128'(0));
  endtask

  task automatic session(input logic [14:0] len);
    i_core_busy = 1'b0;
    step();
    step();
    i_s_len = len;
    step();
    i_core_busy = 1'b1;
    step();
    step();
  endtask

  task automatic req_s(input string nm, input int cnt, input int addr,
                       input int pass, input logic cfg);
    i_request_s = 1'b1;
    step();
    i_request_s = 1'b0;
    chk({nm, " cfg_err"}, 128'(o_cfg_err), 128'(cfg));
    chk({nm, " early cnt"}, 128'(o_s_cnt), 128'(0));
    step();
    chk({nm, " cnt"}, 128'(o_s_cnt), 128'(cnt));
    chk({nm, " data"}, o_s, s_exp(addr, cnt));
    chk({nm, " pass"}, 128'(o_pass_cnt), 128'(pass));
    step();
    chk({nm, " cnt after"}, 128'(o_s_cnt), 128'(0));
  endtask

  task automatic t_burst(input string nm, input int len,
                         input int first, input int exp_w[]);
    i_t_len = 11'(len);
    i_set_t = 1'b1;
    step();
    i_set_t = 1'b0;
    for (int c = 1; c < first; c++) begin
      chk($sformatf("%s pre%0d valid", nm, c), 128'(o_t_valid), 128'(0));
      step();
    end
    for (int k = 0; k < len; k++) begin
      chk($sformatf("%s w%0d valid", nm, k), 128'(o_t_valid), 128'(1));
      chk($sformatf("%s w%0d data", nm, k), 128'(o_t), 128'(exp_w[k]));
      step();
    end
    chk({nm, " end valid"}, 128'(o_t_valid), 128'(0));
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    tbl[0]  = '{15'd150,   1'b1, 64, 0, 0, 1'b0};
    tbl[1]  = '{15'd150,   1'b0, 64, 1, 0, 1'b0};
    tbl[2]  = '{15'd150,   1'b0, 22, 2, 1, 1'b0};
    tbl[3]  = '{15'd128,   1'b1, 64, 0, 0, 1'b0};
    tbl[4]  = '{15'd128,   1'b0, 64, 1, 1, 1'b0};
    tbl[5]  = '{15'd128,   1'b0, 64, 0, 1, 1'b0};
    tbl[6]  = '{15'd128,   1'b0, 64, 1, 2, 1'b0};
    tbl[7]  = '{15'd128,   1'b0, 64, 0, 2, 1'b0};
    tbl[8]  = '{15'd0,     1'b1, 0,  0, 0, 1'b1};
    tbl[9]  = '{15'd16385, 1'b1, 0,  0, 0, 1'b1};
    tbl[10] = '{15'd16384, 1'b1, 64, 0, 0, 1'b0};
    tbl[11] = '{15'd1,     1'b1, 1,  0, 1, 1'b0};
    tbl[12] = '{15'd64,    1'b1, 64, 0, 1, 1'b0};
    tbl[13] = '{15'd200,   1'b1, 64, 0, 0, 1'b0};
    tbl[14] = '{15'd200,   1'b0, 64, 1, 0, 1'b0};
    tbl[15] = '{15'd200,   1'b0, 64, 2, 0, 1'b0};
    tbl[16] = '{15'd200,   1'b0, 8,  3, 1, 1'b0};

    rst_n       = 1'b0;
    i_wr_en     = 1'b0;
    i_wr_sel    = 1'b0;
    i_wr_addr   = '0;
    i_wr_data   = '0;
    i_t_len     = '0;
    i_s_len     = '0;
    i_set_t     = 1'b0;
    i_core_busy = 1'b0;
    i_request_s = 1'b0;
    step();
    step();
    chk_zero("reset");
    rst_n = 1'b1;
    step();

    for (int k = 0; k < 10; k++) wr(1'b0, k, 128'(k));
    chk("load wr_err", 128'(o_wr_err), 128'(0));
    for (int k = 0; k < 4; k++) wr(1'b1, k, s_word(k));

    // t burst of 10; a write attempted mid-burst must be rejected
    i_t_len = 11'd10;
    i_set_t = 1'b1;
    step();
    i_set_t = 1'b0;
    chk("t10 n+1 valid", 128'(o_t_valid), 128'(0));
    for (int k = 0; k < 10; k++) begin
      step();
      if (k == 1) begin
        i_wr_en = 1'b0;
        chk("wr during t", 128'(o_wr_err), 128'(1));
      end
      chk($sformatf("t10 w%0d valid", k), 128'(o_t_valid), 128'(1));
      chk($sformatf("t10 w%0d data", k), 128'(o_t), 128'(k));
      if (k == 0) begin
        i_wr_en   = 1'b1;
        i_wr_sel  = 1'b0;
        i_wr_addr = 10'd5;
        i_wr_data = 128'h155;
      end
    end
    step();
    chk("t10 end valid", 128'(o_t_valid), 128'(0));

    // zero-length burst emits nothing
    i_t_len = 11'd0;
    i_set_t = 1'b1;
    step();
    i_set_t = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("t0 c%0d valid", c), 128'(o_t_valid), 128'(0));
      step();
    end

    // write and set_t together: write lands, burst starts a cycle late
    i_wr_en   = 1'b1;
    i_wr_sel  = 1'b0;
    i_wr_addr = 10'd3;
    i_wr_data = 128'h2A;
    i_t_len   = 11'd4;
    i_set_t   = 1'b1;
    step();
    i_wr_en = 1'b0;
    i_set_t = 1'b0;
    chk("coll wr_err", 128'(o_wr_err), 128'(0));
    t_burst_tail("coll");

    // rejected writes: core busy, and s address out of range
    i_core_busy = 1'b1;
    step();
    wr(1'b0, 1, 128'h3FFFF);
    chk("busy wr_err", 128'(o_wr_err), 128'(1));
    step();
    chk("busy wr_err pulse", 128'(o_wr_err), 128'(0));
    i_core_busy = 1'b0;
    step();
    wr(1'b1, 300, 128'h1);
    chk("range wr_err", 128'(o_wr_err), 128'(1));
    t_burst("readback", 2, 2, '{0, 1});

    for (int i = 0; i < 17; i++) begin
      if (tbl[i].newss) session(tbl[i].len);
      req_s($sformatf("vec%0d", i), tbl[i].cnt, tbl[i].addr,
            tbl[i].pass, tbl[i].cfg);
    end

    // busy drops between acceptance and issue: chunk is dropped
    session(15'd128);
    i_request_s = 1'b1;
    step();
    i_request_s = 1'b0;
    i_core_busy = 1'b0;
    for (int c = 0; c < 3; c++) begin
      chk($sformatf("drop c%0d cnt", c), 128'(o_s_cnt), 128'(0));
      step();
    end
    i_core_busy = 1'b1;
    step();
    step();
    req_s("drop resume0", 64, 0, 0, 1'b0);
    req_s("drop resume1", 64, 1, 1, 1'b0);

    // reset mid t burst with a non-zero pass count
    i_t_len = 11'd10;
    i_set_t = 1'b1;
    step();
    i_set_t = 1'b0;
    step();
    step();
    chk("pre-rst valid", 128'(o_t_valid), 128'(1));
    rst_n = 1'b0;
    #1;
    chk_zero("rst mid");
    step();
    chk_zero("rst hold");
    rst_n = 1'b1;
    step();
    step();
    chk("post-rst t_valid", 128'(o_t_valid), 128'(0));
    i_core_busy = 1'b0;
    step();
    wr(1'b1, 0, s_word(0));
    wr(1'b1, 1, s_word(1));
    session(15'd128);
    req_s("post-rst", 64, 0, 0, 1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

  // Tail of the write/set_t collision: pending cycle, then 4 words.
  task automatic t_burst_tail(input string nm);
    chk({nm, " n+1 valid"}, 128'(o_t_valid), 128'(0));
    step();
    chk({nm, " n+2 valid"}, 128'(o_t_valid), 128'(0));
    for (int k = 0; k < 4; k++) begin
      step();
      chk($sformatf("%s w%0d valid", nm, k), 128'(o_t_valid), 128'(1));
      chk($sformatf("%s w%0d data", nm, k), 128'(o_t),
          128'((k == 3) ? 32'h2A : 32'(k)));
    end
    step();
    chk({nm, " end valid"}, 128'(o_t_valid), 128'(0));
  endtask

endmodule
